hilo_muldiv_unit: RTL and testbench

EX-stage consumer of the decode/execute pipeline register outputs (Mthi/Mtlo/Mfhi/Mflo controls, Read_data_1/2) for MIPS multiply/divide.
- Holds the architectural HI/LO registers and runs iterative MULT/MULTU/DIV/DIVU.
- Raises a stall so the pipeline registers freeze while an operation is in flight.
- Sits beside the ALU; its outputs feed the EX result mux for mfhi/mflo.

---
 rtl/muldiv_defs.sv | 22 ++
 rtl/muldiv_iter_core.sv | 52 +++++
 rtl/hilo_muldiv_unit.sv | 195 +++++++++++++++++++
 tb/tb_hilo_muldiv_unit.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_defs.sv
// Shared definitions for the HI/LO multiply/divide unit: opcodes, FSM states, defaults.
package muldiv_defs;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_ITER  = DEFAULT_WIDTH;

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MUL   = 2'd1,
        DIV   = 2'd2,
        FIXUP = 2'd3
    } state_t;

endpackage

// File: rtl/muldiv_iter_core.sv
// Shared shift/accumulate datapath: unsigned shift-add multiply or restoring divide,
// one step per falling edge. Result is {hi, lo} = product, or {remainder, quotient}.
module muldiv_iter_core #(
    parameter int WIDTH = 32
) (
    input  logic               clock,
    input  logic               load,
    input  logic               step,
    input  logic               mode_div,
    input  logic [WIDTH-1:0]   load_a,
    input  logic [WIDTH-1:0]   load_b,
    output logic [2*WIDTH-1:0] result
);

    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] b_q;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH-1:0] div_diff;
    logic             div_fits;

    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
        div_shift = {hi_q, lo_q[WIDTH-1]};
        div_fits  = (div_shift >= {1'b0, b_q});
        // When the trial subtraction fits, the true difference is below 2^WIDTH,
        // so the truncated subtraction is exact.
        div_diff  = div_shift[WIDTH-1:0] - b_q;
    end

    // Datapath registers carry no reset; the top-level FSM qualifies every use.
    always_ff @(negedge clock) begin
        if (load) begin
            hi_q <= '0;
            lo_q <= load_a;
            b_q  <= load_b;
        end else if (step) begin
            if (mode_div) begin
                hi_q <= div_fits ? div_diff : div_shift[WIDTH-1:0];
                lo_q <= {lo_q[WIDTH-2:0], div_fits};
            end else begin
                hi_q <= mul_sum[WIDTH:1];
                lo_q <= {mul_sum[0], lo_q[WIDTH-1:1]};
            end
        end
    end

    assign result = {hi_q, lo_q};

endmodule

// File: rtl/hilo_muldiv_unit.sv
// EX-stage HI/LO multiply/divide unit with pipeline stall. Define MULDIV_FAST_MULT_EN
// for a single-cycle multiply; divide always stays iterative.
module hilo_muldiv_unit
    import muldiv_defs::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int ITER  = WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             op_valid,
    input  logic [2:0]       op_code,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             hilo_read,
    input  logic             cancel,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(ITER + 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   iter_q;
    logic               is_div_q;
    logic               neg_res_q;
    logic               neg_rem_q;
    logic               zero_div_q;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q;
    logic               dbz_q;

    logic               accept_ok;
    logic               is_mul_op;
    logic               is_div_op;
    logic               signed_op;
    logic               start_mul;
    logic               start_div;
    logic               b_zero;
    logic               iter_last;
    logic               fixup_exit;
    logic               commit;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [2*WIDTH-1:0] core_result;
    logic [2*WIDTH-1:0] mul_raw;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0]   quotient;
    logic [WIDTH-1:0]   remainder;

    function automatic logic [WIDTH-1:0] abs_if(input logic [WIDTH-1:0] v, input logic en);
        return (en && v[WIDTH-1]) ? -v : v;
    endfunction

    function automatic logic [WIDTH-1:0] neg_narrow(input logic [WIDTH-1:0] v, input logic en);
        return en ? -v : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_wide(input logic [2*WIDTH-1:0] v, input logic en);
        return en ? -v : v;
    endfunction

    always_comb begin
        accept_ok = (state_q == IDLE) && op_valid && !cancel;
        is_mul_op = (op_code == OP_MULT) || (op_code == OP_MULTU);
        is_div_op = (op_code == OP_DIV)  || (op_code == OP_DIVU);
        signed_op = (op_code == OP_MULT) || (op_code == OP_DIV);
        start_mul = accept_ok && is_mul_op;
        start_div = accept_ok && is_div_op;
        b_zero    = (operand_b == '0);
        mag_a     = abs_if(operand_a, signed_op);
        mag_b     = abs_if(operand_b, signed_op);
        iter_last = (iter_q == CNT_W'(ITER - 1));
    end

    muldiv_iter_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clock   (clock),
        .load    (start_mul || start_div),
        .step    ((state_q == MUL) || (state_q == DIV)),
        .mode_div(state_q == DIV),
        .load_a  (mag_a),
        .load_b  (mag_b),
        .result  (core_result)
    );

`ifdef MULDIV_FAST_MULT_EN
    logic [WIDTH-1:0] fast_a_q;
    logic [WIDTH-1:0] fast_b_q;

    always_ff @(negedge clock) begin
        if (start_mul) begin
            fast_a_q <= mag_a;
            fast_b_q <= mag_b;
        end
    end

    assign mul_raw = {{WIDTH{1'b0}}, fast_a_q} * {{WIDTH{1'b0}}, fast_b_q};
`else
    assign mul_raw = core_result;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_mul) begin
`ifdef MULDIV_FAST_MULT_EN
                    state_d = FIXUP;
`else
                    state_d = MUL;
`endif
                end else if (start_div) begin
                    state_d = b_zero ? FIXUP : DIV;
                end
            end
            MUL, DIV: begin
                if (cancel)
                    state_d = IDLE;
                else if (iter_last)
                    state_d = FIXUP;
            end
            FIXUP:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Sign fix-up and HI/LO write selection
    always_comb begin
        product    = neg_wide(mul_raw, neg_res_q);
        quotient   = neg_narrow(core_result[WIDTH-1:0], neg_res_q);
        remainder  = neg_narrow(core_result[2*WIDTH-1:WIDTH], neg_rem_q);
        fixup_exit = (state_q == FIXUP) && !cancel;
        commit     = fixup_exit && !zero_div_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        if (commit) begin
            if (is_div_q) begin
                hi_d = remainder;
                lo_d = quotient;
            end else begin
                hi_d = product[2*WIDTH-1:WIDTH];
                lo_d = product[WIDTH-1:0];
            end
        end else if (accept_ok && (op_code == OP_MTHI)) begin
            hi_d = operand_a;
        end else if (accept_ok && (op_code == OP_MTLO)) begin
            lo_d = operand_a;
        end
    end

    always_ff @(negedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
            dbz_q      <= 1'b0;
            iter_q     <= '0;
            is_div_q   <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            zero_div_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= fixup_exit;
            dbz_q   <= fixup_exit && zero_div_q;
            if (start_mul || start_div) begin
                iter_q     <= '0;
                is_div_q   <= start_div;
                neg_res_q  <= signed_op && (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]);
                neg_rem_q  <= signed_op && operand_a[WIDTH-1];
                zero_div_q <= start_div && b_zero;
            end else if ((state_q == MUL) || (state_q == DIV)) begin
                iter_q <= iter_q + CNT_W'(1);
            end
        end
    end

    assign hi_out      = hi_q;
    assign lo_out      = lo_q;
    assign busy        = (state_q != IDLE);
    assign stall       = busy && (hilo_read || op_valid);
    assign done        = done_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed plus randomized bench for hilo_muldiv_unit against an arithmetic reference model.
module tb_hilo_muldiv_unit;
    import muldiv_defs::*;

`ifdef MULDIV_FAST_MULT_EN
    localparam int MUL_BUSY = 1;
`else
    localparam int MUL_BUSY = 33;
`endif
    localparam int DIV_BUSY = 33;

    logic        clock = 1'b0;
    logic        reset;
    logic        op_valid;
    logic [2:0]  op_code;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        hilo_read;
    logic        cancel;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic        busy;
    logic        stall;
    logic        done;
    logic        div_by_zero;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] mhi = 32'h0;
    logic [31:0] mlo = 32'h0;

    hilo_muldiv_unit dut (
        .clock      (clock),
        .reset      (reset),
        .op_valid   (op_valid),
        .op_code    (op_code),
        .operand_a  (operand_a),
        .operand_b  (operand_b),
        .hilo_read  (hilo_read),
        .cancel     (cancel),
        .hi_out     (hi_out),
        .lo_out     (lo_out),
        .busy       (busy),
        .stall      (stall),
        .done       (done),
        .div_by_zero(div_by_zero)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one operation, follow it to completion and compare against the model.
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit probe);
        logic [31:0] eh, el;
        logic [63:0] p;
        longint      la, lb, q, r;
        bit          ez, leak, early_done, stall_bad;
        int          eb, n;
        eh = mhi; el = mlo; ez = 1'b0; eb = 0;
        la = longint'(signed'(a));
        lb = longint'(signed'(b));
        case (op)
            OP_MULT:  begin p = la * lb; eh = p[63:32]; el = p[31:0]; eb = MUL_BUSY; end
            OP_MULTU: begin p = {32'h0, a} * {32'h0, b}; eh = p[63:32]; el = p[31:0]; eb = MUL_BUSY; end
            OP_DIV: begin
                if (b == 32'h0) begin ez = 1'b1; eb = 1; end
                else begin q = la / lb; r = la % lb; el = q[31:0]; eh = r[31:0]; eb = DIV_BUSY; end
            end
            OP_DIVU: begin
                if (b == 32'h0) begin ez = 1'b1; eb = 1; end
                else begin el = a / b; eh = a % b; eb = DIV_BUSY; end
            end
            OP_MTHI: eh = a;
            OP_MTLO: el = a;
            default: ;
        endcase

        op_valid = 1'b1; op_code = op; operand_a = a; operand_b = b;
        @(posedge clock);
        op_valid = 1'b0; op_code = OP_NOP; operand_a = $urandom; operand_b = $urandom;
        n = 0; leak = 1'b0; early_done = 1'b0; stall_bad = 1'b0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            if (hi_out !== mhi || lo_out !== mlo) leak = 1'b1;
            if (done !== 1'b0) early_done = 1'b1;
            if (probe) begin
                hilo_read = 1'b1;
                op_valid  = (n >= 3 && n <= 5);
                op_code   = OP_MTHI;
                operand_a = 32'hDEADBEEF;
                #1;
                if (stall !== 1'b1) stall_bad = 1'b1;
            end
            @(posedge clock);
        end
        op_valid = 1'b0;
        chk("busy_cycles", 64'(n), 64'(eb));
        chk("no_partial_hilo", {63'h0, leak}, 64'h0);
        chk("no_early_done", {63'h0, early_done}, 64'h0);
        if (probe) begin
            chk("stall_while_busy", {63'h0, stall_bad}, 64'h0);
            #1;
            chk("stall_after_busy", {63'h0, stall}, 64'h0);
            hilo_read = 1'b0;
        end
        chk("done_pulse", {63'h0, done}, {63'h0, (eb > 0)});
        chk("div_by_zero", {63'h0, div_by_zero}, {63'h0, ez});
        chk("hi", {32'h0, hi_out}, {32'h0, eh});
        chk("lo", {32'h0, lo_out}, {32'h0, el});
        mhi = eh; mlo = el;
        @(posedge clock);
        chk("done_one_cycle", {63'h0, done}, 64'h0);
        chk("dbz_one_cycle", {63'h0, div_by_zero}, 64'h0);
    endtask

    initial begin
        reset = 1'b1; op_valid = 1'b0; op_code = OP_NOP; operand_a = '0; operand_b = '0;
        hilo_read = 1'b0; cancel = 1'b0;
        repeat (2) @(posedge clock);
        chk("reset_hi", {32'h0, hi_out}, 64'h0);
        chk("reset_lo", {32'h0, lo_out}, 64'h0);
        chk("reset_busy", {63'h0, busy}, 64'h0);
        chk("reset_done", {63'h0, done}, 64'h0);
        chk("reset_dbz", {63'h0, div_by_zero}, 64'h0);
        reset = 1'b0;
        @(posedge clock);

        do_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        chk("tp1_hi", {32'h0, hi_out}, 64'hFFFFFFFE);
        chk("tp1_lo", {32'h0, lo_out}, 64'h00000001);
        do_op(OP_MULT, 32'hFFFFFFFD, 32'h7, 1'b0);
        chk("tp2a_lo", {32'h0, lo_out}, 64'hFFFFFFEB);
        do_op(OP_MULT, 32'h80000000, 32'h80000000, 1'b0);
        chk("tp2b_hi", {32'h0, hi_out}, 64'h40000000);
        do_op(OP_DIV, 32'hFFFFFFF9, 32'h2, 1'b0);
        chk("tp3a_lo", {32'h0, lo_out}, 64'hFFFFFFFD);
        chk("tp3a_hi", {32'h0, hi_out}, 64'hFFFFFFFF);
        do_op(OP_DIVU, 32'hFFFFFFF9, 32'h2, 1'b0);
        chk("tp3b_lo", {32'h0, lo_out}, 64'h7FFFFFFC);
        do_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        chk("tp3c_lo", {32'h0, lo_out}, 64'h80000000);
        chk("tp3c_hi", {32'h0, hi_out}, 64'h0);

        do_op(OP_MTHI, 32'h11, 32'h0, 1'b0);
        do_op(OP_MTLO, 32'h22, 32'h0, 1'b0);
        do_op(OP_DIV, 32'h5, 32'h0, 1'b0);
        chk("tp4_hi_kept", {32'h0, hi_out}, 64'h11);
        chk("tp4_lo_kept", {32'h0, lo_out}, 64'h22);

        do_op(OP_MTHI, 32'h12345678, 32'h0, 1'b0);
        chk("tp5_mthi", {32'h0, hi_out}, 64'h12345678);
        do_op(OP_DIV, 32'h7FFF1234, 32'hFFFFFF13, 1'b1);
        do_op(3'd7, 32'hCAFEF00D, 32'h3, 1'b0);
        do_op(OP_NOP, 32'hCAFEF00D, 32'h3, 1'b0);

        // Cancel wins over an accept in IDLE
        op_valid = 1'b1; op_code = OP_MTLO; operand_a = 32'hBADBAD00; cancel = 1'b1;
        @(posedge clock);
        op_valid = 1'b0; cancel = 1'b0;
        chk("idle_cancel_lo", {32'h0, lo_out}, {32'h0, mlo});
        chk("idle_cancel_busy", {63'h0, busy}, 64'h0);

        // Cancel on the 10th busy cycle of a divide
        op_valid = 1'b1; op_code = OP_DIVU; operand_a = 32'h12345678; operand_b = 32'h3;
        @(posedge clock);
        op_valid = 1'b0;
        for (int i = 1; i < 10; i++) @(posedge clock);
        chk("cancel_busy_before", {63'h0, busy}, 64'h1);
        cancel = 1'b1;
        @(posedge clock);
        cancel = 1'b0;
        chk("cancel_busy", {63'h0, busy}, 64'h0);
        chk("cancel_done", {63'h0, done}, 64'h0);
        @(posedge clock);
        chk("cancel_done_later", {63'h0, done}, 64'h0);
        chk("cancel_hi", {32'h0, hi_out}, {32'h0, mhi});
        chk("cancel_lo", {32'h0, lo_out}, {32'h0, mlo});

        // Reset in the middle of a multiply
        op_valid = 1'b1; op_code = OP_MULTU; operand_a = 32'h00012345; operand_b = 32'h00067890;
        @(posedge clock);
        op_valid = 1'b0;
        reset = 1'b1;
        @(posedge clock);
        reset = 1'b0;
        mhi = 32'h0; mlo = 32'h0;
        chk("rst_mid_hi", {32'h0, hi_out}, 64'h0);
        chk("rst_mid_lo", {32'h0, lo_out}, 64'h0);
        chk("rst_mid_busy", {63'h0, busy}, 64'h0);
        @(posedge clock);
        chk("rst_mid_done", {63'h0, done}, 64'h0);
        chk("rst_mid_lo_later", {32'h0, lo_out}, 64'h0);

        for (int i = 0; i < 40; i++) begin
            logic [2:0]  rop;
            logic [31:0] ra, rb;
            rop = 3'($urandom_range(1, 6));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'h0;
                1: ra = 32'h80000000;
                2: rb = 32'hFFFFFFFF;
                3: rb = 32'($urandom_range(1, 9));
                default: ;
            endcase
            do_op(rop, ra, rb, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
